// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
//   Shared definitions for the memory bus arbiter slice.
//   - state_t               : arbiter FSM state encoding
//   - REQ_CPU / REQ_DMA     : requester id constants (owner / last_grant values)
//   - WAIT_CYCLES_DEFAULT   : default number of memory wait states
//   - WAIT_W                : wait counter width (WAIT_CYCLES legal range 0..15)
//   - grant_owner()         : converts a one-hot grant into a requester id
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    localparam int WAIT_CYCLES_DEFAULT = 1;
    localparam int WAIT_W              = 4;

    // Only meaningful for a one-hot (or zero) grant vector.
    function automatic logic grant_owner(input logic [1:0] grant);
        return grant[1] ? REQ_DMA : REQ_CPU;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
//   Bundles the two requester handshakes and the memory port of the arbiter.
//   Requester N (N = 0 CPU, 1 loader/DMA):
//     rN_valid / rN_ready          request handshake
//     rN_we, rN_addr, rN_wdata     request payload
//     rN_rsp_valid, rN_rsp_rdata   one-cycle completion pulse and read data
//   Memory port:
//     mem_en, mem_we, mem_addr, mem_wdata  access strobe and payload
//     mem_rdata                            read data returned by memory
//   Modports:
//     slave  : the arbiter's view (accepts requests, drives memory)
//     master : the requesters' and memory's view
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              r0_valid;
    logic              r0_ready;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_rsp_valid;
    logic [DATA_W-1:0] r0_rsp_rdata;

    logic              r1_valid;
    logic              r1_ready;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_rsp_valid;
    logic [DATA_W-1:0] r1_rsp_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  r0_valid, r0_we, r0_addr, r0_wdata,
        output r0_ready, r0_rsp_valid, r0_rsp_rdata,
        input  r1_valid, r1_we, r1_addr, r1_wdata,
        output r1_ready, r1_rsp_valid, r1_rsp_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output r0_valid, r0_we, r0_addr, r0_wdata,
        input  r0_ready, r0_rsp_valid, r0_rsp_rdata,
        output r1_valid, r1_we, r1_addr, r1_wdata,
        input  r1_ready, r1_rsp_valid, r1_rsp_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// rr_arbiter2
//   Combinational two-way round-robin grant.
//   Ports:
//     req[1:0]    in   request bits (bit 0 = CPU, bit 1 = loader/DMA)
//     last_grant  in   id of the requester granted most recently
//     grant[1:0]  out  one-hot grant, all zero when nothing is requested
//   A lone requester always wins; on contention the requester that was not
//   granted last wins, which makes continuous contention strictly alternate.
module rr_arbiter2
    import mem_bus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == REQ_DMA) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one memory port between the CPU bus (requester 0) and the
//   loader/DMA port (requester 1), one transaction at a time.
//   Ports:
//     clk    in   rising-edge clock
//     reset  in   asynchronous, active-high reset
//     bus    slave modport of mem_bus_arbiter_if (requests, responses, memory)
//   Parameters:
//     ADDR_W, DATA_W  address / data widths
//     WAIT_CYCLES     extra memory cycles per access, 0..15
//   Timing: request accepted at T, mem_en high T+1..T+WAIT_CYCLES+1,
//   rsp_valid at T+WAIT_CYCLES+2, next grant possible at T+WAIT_CYCLES+3.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for a request; ready is offered to the granted one
//   ACCESS | memory port driven from registered request, wait count runs
//   RESP   | one-cycle response pulse to the owner, no new grant
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    mem_bus_arbiter_if.slave  bus
);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_wait_range
        $error("mem_bus_arbiter: WAIT_CYCLES must be in 0..15");
    end

    state_t state;
    state_t state_nxt;

    logic [1:0]        grant;
    logic              grant_id;
    logic              take;
    logic              access_done;

    logic              last_grant;
    logic              owner;
    logic [WAIT_W-1:0] wait_cnt;

    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic              rsp_valid0_q;
    logic              rsp_valid1_q;
    logic [DATA_W-1:0] rsp_rdata0_q;
    logic [DATA_W-1:0] rsp_rdata1_q;

    rr_arbiter2 u_rr_arbiter2 (
        .req        ({bus.r1_valid, bus.r0_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign grant_id = grant_owner(grant);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake strobes
    always_comb begin
        state_nxt   = state;
        take        = 1'b0;
        access_done = 1'b0;
        case (state)
            IDLE: begin
                // Gated with reset so ready reads 0 while reset is held.
                if (!reset && grant != 2'b00) begin
                    take      = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (wait_cnt == '0) begin
                    access_done = 1'b1;
                    state_nxt   = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: request capture, wait counter, memory port, responses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant   <= REQ_DMA;
            owner        <= REQ_CPU;
            wait_cnt     <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rsp_valid0_q <= 1'b0;
            rsp_valid1_q <= 1'b0;
            rsp_rdata0_q <= '0;
            rsp_rdata1_q <= '0;
        end else begin
            rsp_valid0_q <= 1'b0;
            rsp_valid1_q <= 1'b0;
            if (take) begin
                owner      <= grant_id;
                last_grant <= grant_id;
                wait_cnt   <= WAIT_W'(WAIT_CYCLES);
                mem_en_q   <= 1'b1;
                if (grant_id == REQ_DMA) begin
                    mem_we_q    <= bus.r1_we;
                    mem_addr_q  <= bus.r1_addr;
                    mem_wdata_q <= bus.r1_wdata;
                end else begin
                    mem_we_q    <= bus.r0_we;
                    mem_addr_q  <= bus.r0_addr;
                    mem_wdata_q <= bus.r0_wdata;
                end
            end else if (state == ACCESS) begin
                if (access_done) begin
                    // Memory port drops back to zero as RESP begins.
                    mem_en_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    if (owner == REQ_DMA) begin
                        rsp_valid1_q <= 1'b1;
                        rsp_rdata1_q <= mem_we_q ? '0 : bus.mem_rdata;
                    end else begin
                        rsp_valid0_q <= 1'b1;
                        rsp_rdata0_q <= mem_we_q ? '0 : bus.mem_rdata;
                    end
                end else begin
                    wait_cnt <= wait_cnt - WAIT_W'(1);
                end
            end
        end
    end

    assign bus.r0_ready     = take & grant[0];
    assign bus.r1_ready     = take & grant[1];
    assign bus.r0_rsp_valid = rsp_valid0_q;
    assign bus.r1_rsp_valid = rsp_valid1_q;
    assign bus.r0_rsp_rdata = rsp_rdata0_q;
    assign bus.r1_rsp_rdata = rsp_rdata1_q;
    assign bus.mem_en       = mem_en_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Three arbiter instances (WAIT_CYCLES = 1, 0, 15) share one clock. A
//   transaction-level model per instance predicts every output each cycle;
//   directed scenarios add hand-computed literal expectations.
//   Memory read data is modelled as mem_addr ^ KEY.
module tb_mem_bus_arbiter;

    localparam logic [31:0] KEY = 32'hDEAD_BEFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       rst;
    logic [2:0]       r0_valid, r0_we, r1_valid, r1_we;
    logic [2:0][31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;

    wire  [2:0]       r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, mem_en, mem_we;
    wire  [2:0][31:0] r0_rsp_rdata, r1_rsp_rdata, mem_addr, mem_wdata;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_bus_arbiter_if bus ();
        assign bus.r0_valid  = r0_valid[g];
        assign bus.r0_we     = r0_we[g];
        assign bus.r0_addr   = r0_addr[g];
        assign bus.r0_wdata  = r0_wdata[g];
        assign bus.r1_valid  = r1_valid[g];
        assign bus.r1_we     = r1_we[g];
        assign bus.r1_addr   = r1_addr[g];
        assign bus.r1_wdata  = r1_wdata[g];
        assign bus.mem_rdata = bus.mem_addr ^ KEY;
        assign r0_ready[g]     = bus.r0_ready;
        assign r1_ready[g]     = bus.r1_ready;
        assign r0_rsp_valid[g] = bus.r0_rsp_valid;
        assign r1_rsp_valid[g] = bus.r1_rsp_valid;
        assign r0_rsp_rdata[g] = bus.r0_rsp_rdata;
        assign r1_rsp_rdata[g] = bus.r1_rsp_rdata;
        assign mem_en[g]       = bus.mem_en;
        assign mem_we[g]       = bus.mem_we;
        assign mem_addr[g]     = bus.mem_addr;
        assign mem_wdata[g]    = bus.mem_wdata;

        mem_bus_arbiter #(
            .WAIT_CYCLES (g == 0 ? 1 : (g == 1 ? 0 : 15))
        ) u_dut (
            .clk   (clk),
            .reset (rst[g]),
            .bus   (bus)
        );
    end

    function automatic int wc(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 0 : 15);
    endfunction

    int n_tests;
    int n_fail;
    int cyc;

    // Model: ph = -1 idle, otherwise cycles elapsed since the grant edge.
    int          ph      [3];
    logic        m_owner [3];
    logic        m_we    [3];
    logic        m_last  [3];
    logic [31:0] m_addr  [3];
    logic [31:0] m_wdata [3];
    logic [31:0] m_rd    [3][2];

    // Observations of the DUTs, used by the literal checks.
    int          gcnt      [3];
    int          glog      [3][16];
    int          grant_cyc [3][2];
    int          rsp_cyc   [3][2];
    int          rsp_cnt   [3][2];
    logic [31:0] rsp_dat   [3][2];
    int          en_cnt    [3];
    logic [31:0] en_addr   [3];
    logic [31:0] en_wdata  [3];
    logic        en_we     [3];
    int          dual      [3];

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [dut%0d cyc %0d] got %h want %h", name, g, cyc, act, exp);
        end
    endtask

    // Per-cycle compare, sampled 3 time units after the falling edge (before
    // the next rising edge), then the model advances across that edge.
    always begin : compare
        logic e0, e1, en_x, rsp_x, any_v, gid;
        int   w;
        @(negedge clk);
        #3;
        cyc++;
        for (int g = 0; g < 3; g++) begin
            w = wc(g);
            if (rst[g]) begin
                ph[g] = -1; m_owner[g] = 1'b0; m_we[g] = 1'b0; m_last[g] = 1'b1;
                m_addr[g] = '0; m_wdata[g] = '0; m_rd[g][0] = '0; m_rd[g][1] = '0;
            end
            any_v = r0_valid[g] | r1_valid[g];
            gid   = (r0_valid[g] && r1_valid[g]) ? ~m_last[g] : r1_valid[g];
            e0    = (ph[g] < 0) && !rst[g] && any_v && (gid == 1'b0);
            e1    = (ph[g] < 0) && !rst[g] && any_v && (gid == 1'b1);
            en_x  = (ph[g] >= 1) && (ph[g] <= w + 1);
            rsp_x = (ph[g] == w + 2);

            chk("r0_ready", g, 32'(r0_ready[g]), 32'(e0));
            chk("r1_ready", g, 32'(r1_ready[g]), 32'(e1));
            chk("mem_en", g, 32'(mem_en[g]), 32'(en_x));
            chk("mem_we", g, 32'(mem_we[g]), 32'(en_x && m_we[g]));
            chk("mem_addr", g, mem_addr[g], en_x ? m_addr[g] : 32'h0);
            chk("mem_wdata", g, mem_wdata[g], en_x ? m_wdata[g] : 32'h0);
            chk("r0_rsp_valid", g, 32'(r0_rsp_valid[g]), 32'(rsp_x && m_owner[g] == 1'b0));
            chk("r1_rsp_valid", g, 32'(r1_rsp_valid[g]), 32'(rsp_x && m_owner[g] == 1'b1));
            chk("r0_rsp_rdata", g, r0_rsp_rdata[g], m_rd[g][0]);
            chk("r1_rsp_rdata", g, r1_rsp_rdata[g], m_rd[g][1]);

            if (r0_ready[g] && r1_ready[g]) dual[g]++;
            if (r0_ready[g]) begin
                if (gcnt[g] < 16) glog[g][gcnt[g]] = 0;
                gcnt[g]++;
                grant_cyc[g][0] = cyc;
            end
            if (r1_ready[g]) begin
                if (gcnt[g] < 16) glog[g][gcnt[g]] = 1;
                gcnt[g]++;
                grant_cyc[g][1] = cyc;
            end
            if (mem_en[g]) begin
                en_cnt[g]++;
                en_addr[g]  = mem_addr[g];
                en_wdata[g] = mem_wdata[g];
                en_we[g]    = mem_we[g];
            end
            if (r0_rsp_valid[g]) begin
                rsp_cnt[g][0]++; rsp_cyc[g][0] = cyc; rsp_dat[g][0] = r0_rsp_rdata[g];
            end
            if (r1_rsp_valid[g]) begin
                rsp_cnt[g][1]++; rsp_cyc[g][1] = cyc; rsp_dat[g][1] = r1_rsp_rdata[g];
            end

            if (!rst[g]) begin
                if (ph[g] < 0) begin
                    if (any_v) begin
                        m_owner[g] = gid;
                        m_last[g]  = gid;
                        m_we[g]    = gid ? r1_we[g]    : r0_we[g];
                        m_addr[g]  = gid ? r1_addr[g]  : r0_addr[g];
                        m_wdata[g] = gid ? r1_wdata[g] : r0_wdata[g];
                        ph[g]      = 1;
                    end
                end else if (en_x) begin
                    if (ph[g] == w + 1)
                        m_rd[g][m_owner[g]] = m_we[g] ? 32'h0 : (m_addr[g] ^ KEY);
                    ph[g]++;
                end else begin
                    ph[g] = -1;
                end
            end
        end
    end

    // Called on a falling edge; returns on a later falling edge with valid dropped.
    task automatic req(input int g, input bit r, input logic we, input logic [31:0] a, input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        if (r) begin
            r1_valid[g] = 1'b1; r1_we[g] = we; r1_addr[g] = a; r1_wdata[g] = d;
        end else begin
            r0_valid[g] = 1'b1; r0_we[g] = we; r0_addr[g] = a; r0_wdata[g] = d;
        end
        for (int i = 0; i < 64; i++) begin
            #4;
            if ((r ? r1_ready[g] : r0_ready[g]) == 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("req_accept_timeout", g, 32'(ok), 32'd1);
        @(negedge clk);
        if (r) r1_valid[g] = 1'b0;
        else   r0_valid[g] = 1'b0;
    endtask

    task automatic wait_rsp(input int g, input bit r);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            #4;
            if ((r ? r1_rsp_valid[g] : r0_rsp_valid[g]) == 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rsp_timeout", g, 32'(ok), 32'd1);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #60000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin : stim
        int e0, c0, c1, b;
        n_tests = 0; n_fail = 0; cyc = 0;
        for (int g = 0; g < 3; g++) begin
            ph[g] = -1; m_owner[g] = 1'b0; m_we[g] = 1'b0; m_last[g] = 1'b1;
            m_addr[g] = '0; m_wdata[g] = '0; m_rd[g][0] = '0; m_rd[g][1] = '0;
            gcnt[g] = 0; en_cnt[g] = 0; dual[g] = 0;
            en_addr[g] = '0; en_wdata[g] = '0; en_we[g] = 1'b0;
            for (int r = 0; r < 2; r++) begin
                grant_cyc[g][r] = 0; rsp_cyc[g][r] = 0; rsp_cnt[g][r] = 0; rsp_dat[g][r] = '0;
            end
            for (int k = 0; k < 16; k++) glog[g][k] = -1;
        end
        rst = '1;
        r0_valid = '0; r0_we = '0; r1_valid = '0; r1_we = '0;
        r0_addr = '0; r0_wdata = '0; r1_addr = '0; r1_wdata = '0;

        // Contention on dut0 (WAIT_CYCLES=1): both requesters valid from reset.
        r0_valid[0] = 1'b1; r0_addr[0] = 32'h100;
        r1_valid[0] = 1'b1; r1_addr[0] = 32'h200;
        repeat (3) @(negedge clk);
        rst = '0;
        b = 0;
        while (gcnt[0] < 4 && b < 60) begin
            @(negedge clk);
            #4;
            b++;
        end
        @(negedge clk);
        r0_valid[0] = 1'b0; r1_valid[0] = 1'b0;
        repeat (8) @(negedge clk);
        chk("contention_grant_count", 0, gcnt[0], 4);
        for (int i = 0; i < 4; i++) chk("contention_order", 0, glog[0][i], i % 2);
        chk("contention_dual_ready", 0, dual[0], 0);
        chk("contention_r0_rsps", 0, rsp_cnt[0][0], 2);
        chk("contention_r1_rsps", 0, rsp_cnt[0][1], 2);
        chk("contention_r0_data", 0, rsp_dat[0][0], 32'hDEADBFFF);
        chk("contention_r1_data", 0, rsp_dat[0][1], 32'hDEADBCFF);

        // Single read on dut0.
        e0 = en_cnt[0]; c1 = rsp_cnt[0][1];
        req(0, 1'b0, 1'b0, 32'h10, 32'h0);
        wait_rsp(0, 1'b0);
        chk("read_mem_en_cycles", 0, en_cnt[0] - e0, 2);
        chk("read_mem_addr", 0, en_addr[0], 32'h10);
        chk("read_mem_we", 0, 32'(en_we[0]), 32'd0);
        chk("read_latency", 0, rsp_cyc[0][0] - grant_cyc[0][0], 3);
        chk("read_rdata", 0, rsp_dat[0][0], 32'hDEADBEEF);
        chk("read_no_r1_rsp", 0, rsp_cnt[0][1] - c1, 0);

        // Write on dut1 (WAIT_CYCLES=0).
        req(1, 1'b1, 1'b1, 32'h20, 32'h55AA);
        wait_rsp(1, 1'b1);
        chk("write_mem_en_cycles", 1, en_cnt[1], 1);
        chk("write_mem_addr", 1, en_addr[1], 32'h20);
        chk("write_mem_wdata", 1, en_wdata[1], 32'h55AA);
        chk("write_mem_we", 1, 32'(en_we[1]), 32'd1);
        chk("write_latency", 1, rsp_cyc[1][1] - grant_cyc[1][1], 2);
        chk("write_rdata_zero", 1, rsp_dat[1][1], 32'h0);
        chk("write_no_r0_rsp", 1, rsp_cnt[1][0], 0);

        // Late arrival on dut0: r1 raised during r0's ACCESS.
        req(0, 1'b0, 1'b0, 32'h30, 32'h0);
        req(0, 1'b1, 1'b0, 32'h40, 32'h0);
        wait_rsp(0, 1'b1);
        chk("late_grant_after_rsp", 0, grant_cyc[0][1] - rsp_cyc[0][0], 1);
        chk("late_grant_spacing", 0, grant_cyc[0][1] - grant_cyc[0][0], 4);
        chk("late_r1_data", 0, rsp_dat[0][1], 32'hDEADBEBF);

        // Reset during ACCESS on dut0.
        c0 = rsp_cnt[0][0]; c1 = rsp_cnt[0][1];
        req(0, 1'b0, 1'b0, 32'h50, 32'h0);
        rst[0] = 1'b1;
        #1;
        chk("reset_mem_en", 0, 32'(mem_en[0]), 32'd0);
        chk("reset_mem_addr", 0, mem_addr[0], 32'h0);
        repeat (3) @(negedge clk);
        chk("reset_no_r0_rsp", 0, rsp_cnt[0][0] - c0, 0);
        chk("reset_no_r1_rsp", 0, rsp_cnt[0][1] - c1, 0);
        r0_valid[0] = 1'b1; r0_we[0] = 1'b0; r0_addr[0] = 32'h60;
        r1_valid[0] = 1'b1; r1_we[0] = 1'b0; r1_addr[0] = 32'h70;
        @(negedge clk);
        rst[0] = 1'b0;
        #4;
        chk("post_reset_r0_ready", 0, 32'(r0_ready[0]), 32'd1);
        chk("post_reset_r1_ready", 0, 32'(r1_ready[0]), 32'd0);
        @(negedge clk);
        r0_valid[0] = 1'b0;
        req(0, 1'b1, 1'b0, 32'h70, 32'h0);
        wait_rsp(0, 1'b1);
        chk("post_reset_r0_rsps", 0, rsp_cnt[0][0] - c0, 1);
        chk("post_reset_r1_rsps", 0, rsp_cnt[0][1] - c1, 1);
        chk("post_reset_r0_data", 0, rsp_dat[0][0], 32'hDEADBE9F);

        // WAIT_CYCLES=15 read on dut2.
        req(2, 1'b0, 1'b0, 32'h80, 32'h0);
        wait_rsp(2, 1'b0);
        chk("w15_mem_en_cycles", 2, en_cnt[2], 16);
        chk("w15_latency", 2, rsp_cyc[2][0] - grant_cyc[2][0], 17);
        chk("w15_rdata", 2, rsp_dat[2][0], 32'hDEADBE7F);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
